// File: rtl/ship_pkg.sv
// Shared types and helpers for the multi-string GRB ship sequencer.
// The ERR state is only reachable when SHIP_TIMEOUT_EN is defined.
package ship_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIP    = 3'd1,
    GAP     = 3'd2,
    LATCH   = 3'd3,
    DBOUNCE = 3'd4,
    ERR     = 3'd5
  } state_t;

  localparam int DEFAULT_LATCH_CYCLES = 6000;

  // Width of a string index; a single string still gets one bit.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ship_next_ch.sv
// Priority encoder: lowest set bit of mask strictly above cur, or the lowest
// set bit overall when from_start is high.
module ship_next_ch
  import ship_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              from_start,
  output logic [CH_W-1:0]   next,
  output logic              valid
);

  // Scanning downwards leaves the lowest qualifying bit as the final winner.
  always_comb begin
    next  = '0;
    valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur)))) begin
        next  = CH_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ship_sequencer.sv
// Sequences GRB shipping across NUM_CH strings in mask order, then holds the
// WS2812 latch gap. Optional SHIP watchdog enabled by defining SHIP_TIMEOUT_EN.
module ship_sequencer
  import ship_pkg::*;
#(
  parameter  int NUM_CH         = 4,
  parameter  int LATCH_CYCLES   = DEFAULT_LATCH_CYCLES,
  parameter  int FCNT_W         = 8,
  parameter  int TIMEOUT_CYCLES = 1000000,
  localparam int CH_W           = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              done,
  input  logic              in_loop,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] ship_grb,
  output logic [CH_W-1:0]   ch_sel,
  output logic              latching,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              timeout_err,
  output state_t            dbg_state
);

  localparam int LW = (LATCH_CYCLES <= 1) ? 1 : $clog2(LATCH_CYCLES);

  // Handshake: ship_grb holds one-hot on the active string from the first SHIP
  // cycle until done is sampled high on a clk edge; done has no effect elsewhere.
  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [LW-1:0]       lcnt_q, lcnt_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [NUM_CH-1:0]   ship_grb_q;
  logic [CH_W-1:0]     first_ch, next_ch;
  logic                start_ok, more_ok, last_latch;

`ifdef SHIP_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES <= 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0]     wdog_q, wdog_d;
`endif

  ship_next_ch #(.NUM_CH(NUM_CH)) u_first (
    .mask       (ch_mask),
    .cur        ('0),
    .from_start (1'b1),
    .next       (first_ch),
    .valid      (start_ok)
  );

  ship_next_ch #(.NUM_CH(NUM_CH)) u_next (
    .mask       (mask_q),
    .cur        (ch_sel_q),
    .from_start (1'b0),
    .next       (next_ch),
    .valid      (more_ok)
  );

  assign last_latch = (state_q == LATCH) && (lcnt_q == LW'(LATCH_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    mask_d   = mask_q;
    lcnt_d   = lcnt_q;
    fcnt_d   = fcnt_q;
`ifdef SHIP_TIMEOUT_EN
    wdog_d   = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (go && start_ok) begin
          mask_d   = ch_mask;
          ch_sel_d = first_ch;
          state_d  = SHIP;
`ifdef SHIP_TIMEOUT_EN
          wdog_d   = '0;
`endif
        end
      end
      SHIP: begin
        if (done) begin
          if (more_ok) begin
            state_d = GAP;
          end else begin
            state_d = LATCH;
            lcnt_d  = '0;
          end
        end
`ifdef SHIP_TIMEOUT_EN
        else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      GAP: begin
        ch_sel_d = next_ch;
        state_d  = SHIP;
`ifdef SHIP_TIMEOUT_EN
        wdog_d   = '0;
`endif
      end
      LATCH: begin
        lcnt_d = lcnt_q + 1'b1;
        if (last_latch) begin
          fcnt_d = fcnt_q + 1'b1;
          // The loop restart re-samples ch_mask; an empty mask ends the run.
          if (in_loop && go && start_ok) begin
            mask_d   = ch_mask;
            ch_sel_d = first_ch;
            state_d  = SHIP;
`ifdef SHIP_TIMEOUT_EN
            wdog_d   = '0;
`endif
          end else if (!in_loop && go) begin
            state_d = DBOUNCE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DBOUNCE: begin
        if (!go) state_d = IDLE;
      end
`ifdef SHIP_TIMEOUT_EN
      ERR: begin
        if (!go) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ch_sel_q   <= '0;
      mask_q     <= '0;
      lcnt_q     <= '0;
      fcnt_q     <= '0;
      ship_grb_q <= '0;
`ifdef SHIP_TIMEOUT_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ch_sel_q   <= ch_sel_d;
      mask_q     <= mask_d;
      lcnt_q     <= lcnt_d;
      fcnt_q     <= fcnt_d;
      ship_grb_q <= (state_d == SHIP) ? (NUM_CH'(1) << ch_sel_d) : '0;
`ifdef SHIP_TIMEOUT_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign ship_grb   = ship_grb_q;
  assign ch_sel     = ch_sel_q;
  assign latching   = (state_q == LATCH);
  assign busy       = (state_q != IDLE);
  assign frame_done = last_latch;
  assign frame_cnt  = fcnt_q;
  assign dbg_state  = state_q;
`ifdef SHIP_TIMEOUT_EN
  assign timeout_err = (state_q == ERR);
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ship_sequencer.sv
// Bench for ship_sequencer: directed scenarios plus random traffic, checked
// every cycle against a queue-based frame model and a ship-order scoreboard.
module tb_ship_sequencer;
  import ship_pkg::*;

  localparam int NUM_CH = 4;
  localparam int LATCH  = 20;
  localparam int FCNT_W = 3;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              go = 1'b0;
  logic              done = 1'b0;
  logic              in_loop = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [NUM_CH-1:0] ship_grb;
  logic [CH_W-1:0]   ch_sel;
  logic              latching, busy, frame_done, timeout_err;
  logic [FCNT_W-1:0] frame_cnt;
  state_t            dbg_state;

  ship_sequencer #(
    .NUM_CH(NUM_CH), .LATCH_CYCLES(LATCH), .FCNT_W(FCNT_W), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .done(done), .in_loop(in_loop),
    .ch_mask(ch_mask), .ship_grb(ship_grb), .ch_sel(ch_sel),
    .latching(latching), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // reference model: a frame is a queue of pending strings
  int  m_pend[$];
  bit  m_active, m_gap, m_hold;
  int  m_latch, m_frames, m_sel;
  int  age, fd_seen;
  logic [NUM_CH-1:0] exp_q[$];
  logic [NUM_CH-1:0] prev_grb;

  task automatic m_reset();
    m_pend.delete();
    m_active = 0; m_gap = 0; m_hold = 0;
    m_latch = 0; m_frames = 0; m_sel = 0;
    age = 0; prev_grb = '0;
    exp_q.delete();
  endtask

  function automatic logic [NUM_CH-1:0] m_grb();
    if (m_active && !m_gap && m_latch == 0 && m_pend.size() > 0)
      return NUM_CH'(1) << m_pend[0];
    return '0;
  endfunction

  task automatic m_start(input logic [NUM_CH-1:0] m);
    m_pend.delete();
    for (int i = 0; i < NUM_CH; i++) if (m[i]) m_pend.push_back(i);
    m_active = 1;
    m_sel = m_pend[0];
    exp_q.push_back(NUM_CH'(1) << m_sel);
  endtask

  task automatic m_step(input logic g, input logic d, input logic l, input logic [NUM_CH-1:0] m);
    if (m_hold) begin
      if (!g) m_hold = 0;
    end else if (m_latch > 0) begin
      m_latch--;
      if (m_latch == 0) begin
        m_frames++;
        m_active = 0;
        if (l && g) begin
          if (m != 0) m_start(m);
        end else if (!l && g) begin
          m_hold = 1;
        end
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_sel = m_pend[0];
      exp_q.push_back(NUM_CH'(1) << m_sel);
    end else if (m_active) begin
      if (d) begin
        void'(m_pend.pop_front());
        if (m_pend.size() > 0) m_gap = 1;
        else m_latch = LATCH;
      end
    end else if (g && m != 0) begin
      m_start(m);
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] eg;
    eg = m_grb();
    check("ship_grb", 32'(ship_grb), 32'(eg));
    check("ch_sel", 32'(ch_sel), 32'(m_sel));
    check("latching", 32'(latching), 32'(m_latch > 0));
    check("busy", 32'(busy), 32'(m_active || m_hold));
    check("frame_done", 32'(frame_done), 32'(m_latch == 1));
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames % (1 << FCNT_W)));
    check("timeout_err", 32'(timeout_err), 32'd0);
    if (ship_grb != 0 && prev_grb == 0) begin
      if (exp_q.size() > 0) check("ship_order", 32'(ship_grb), 32'(exp_q.pop_front()));
      else check("ship_order_extra", 32'(ship_grb), 32'd0);
    end
    prev_grb = ship_grb;
    if (frame_done === 1'b1) fd_seen++;
    if (eg != 0) age++; else age = 0;
  endtask

  // driver tasks (called at negedge)
  task automatic drive_step(input logic g, input logic d, input logic l, input logic [NUM_CH-1:0] m);
    go = g; done = d; in_loop = l; ch_mask = m;
    m_step(g, d, l, m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle(input logic g, input logic d, input logic l, input logic [NUM_CH-1:0] m);
    compare_all();
    drive_step(g, d, l, m);
  endtask

  // Shipper responder: done rises once the model has shipped a string dly cycles.
  task automatic run(input int n, input logic g, input logic l, input logic [NUM_CH-1:0] m, input int dly);
    for (int i = 0; i < n; i++) begin
      compare_all();
      drive_step(g, (m_grb() != 0) && (age >= dly), l, m);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; go = 1'b0; done = 1'b0;
    m_reset();
    @(negedge clk);
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    logic rg, rl;
    logic [NUM_CH-1:0] rm;
    fd_seen = 0;
    m_reset();
    @(negedge clk);
    do_reset();

    // single-shot 1011, go held: ships 0,1,3, latch, debounce
    run(40, 1'b1, 1'b0, 4'b1011, 3);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_dbounce_busy", 32'(busy), 32'd1);
    run(3, 1'b0, 1'b0, 4'b1011, 3);
    check("t1_idle", 32'(busy), 32'd0);

    // loop mode, three frames, go dropped during the third
    do_reset();
    fd_seen = 0;
    run(51, 1'b1, 1'b1, 4'b0001, 3);
    run(30, 1'b0, 1'b1, 4'b0001, 3);
    check("t2_frames", 32'(fd_seen), 32'd3);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd3);
    check("t2_idle", 32'(busy), 32'd0);

    // empty mask never starts; first non-empty mask starts next cycle
    do_reset();
    run(10, 1'b1, 1'b0, 4'b0000, 3);
    check("t3_not_busy", 32'(busy), 32'd0);
    compare_all();
    drive_step(1'b1, 1'b0, 1'b0, 4'b0100);
    check("t3_ship", 32'(ship_grb), 32'b0100);
    run(40, 1'b0, 1'b0, 4'b0100, 3);

    // asynchronous reset while shipping string 1
    run(6, 1'b1, 1'b0, 4'b0011, 3);
    check("t4_pre_sel", 32'(ch_sel), 32'd1);
    check("t4_pre_cnt", 32'(frame_cnt), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t4_rst_grb", 32'(ship_grb), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_latching", 32'(latching), 32'd0);
    check("t4_rst_cnt", 32'(frame_cnt), 32'd0);
    go = 1'b0;
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 4'b0011);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 4'b0001);

    // mask shrinks mid-frame: all four strings still ship
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 4'b1111);
    run(60, 1'b1, 1'b0, 4'b0001, 3);
    run(5, 1'b0, 1'b0, 4'b0001, 3);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t5_order_drained", 32'(exp_q.size()), 32'd0);

    // random traffic
    do_reset();
    rg = 1'b0; rl = 1'b0; rm = 4'b0101;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) rg = ~rg;
      if ($urandom_range(0, 49) == 0) rl = ~rl;
      if ($urandom_range(0, 9) == 0) rm = 4'($urandom_range(0, 15));
      cycle(rg, $urandom_range(0, 2) == 0, rl, rm);
    end
    run(60, 1'b0, 1'b0, 4'b0000, 2);
    check("rand_drained_busy", 32'(busy), 32'd0);
    check("rand_order_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ship_sequencer.md
Name: ship_sequencer

Overview:
- Multi-channel successor to the single-string GRB ship controller.
- Sequences GRB shipping across NUM_CH LED strings, one at a time, in a masked order.
- Enforces the WS2812 latch gap (reset-low interval) after each frame.
- Supports loop mode (continuous frames while go is held) and go-debounce in single-shot mode.
- Sits between the host/CPU control registers and NUM_CH per-string GRB shifters. Each shifter takes a ship strobe and returns done.

Parameters:
- NUM_CH, 4: number of LED strings (1..16).
- LATCH_CYCLES, 6000: clk cycles in LATCH (≥50 us at the system clock).
- FCNT_W, 8: width of the frame counter.
- TIMEOUT_CYCLES, 1000000: SHIP watchdog limit. Used only with SHIP_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  start request, level-sensitive.
- done  in  1  current string's shipper finished. Single-cycle pulse or level.
- in_loop  in  1  1 = loop mode, 0 = single-shot with debounce.
- ch_mask  in  NUM_CH  enabled strings. Bit i enables string i.
- ship_grb  out  NUM_CH  one-hot ship strobe to the active string. All zero when not shipping.
- ch_sel  out  clog2(NUM_CH) (min 1)  index of the active/last string.
- latching  out  1  high throughout LATCH.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse on the last LATCH cycle.
- frame_cnt  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W.
- timeout_err  out  1  sticky watchdog error. Constant 0 without SHIP_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - All outputs 0.
  - Mask latch, latch counter and watchdog cleared.
- States: IDLE, SHIP, GAP, LATCH, DBOUNCE, plus ERR with the optional feature.
- IDLE:
  - go=1 and ch_mask≠0 → latch ch_mask into mask_q, ch_sel = lowest set bit, → SHIP.
  - go=1 with ch_mask=0 → stay IDLE.
- SHIP:
  - ship_grb = one-hot(ch_sel), registered output, asserted from the first SHIP cycle.
  - done is sampled every SHIP cycle, including the first.
  - On done:
    - a higher set bit remains in mask_q → → GAP;
    - otherwise → LATCH.
  - go is ignored in SHIP.
- GAP:
  - Exactly 1 cycle with ship_grb=0, so every shipper sees a fresh rising edge.
  - ch_sel advances to the next set bit above the current one, → SHIP.
- LATCH:
  - latching=1 for exactly LATCH_CYCLES cycles.
  - On the final cycle: frame_done=1 and frame_cnt increments.
  - Exit, evaluated on the final cycle:
    - in_loop=1, go=1 → re-sample ch_mask. If nonzero → SHIP at its lowest bit; if zero → IDLE.
    - in_loop=1, go=0 → IDLE.
    - in_loop=0, go=1 → DBOUNCE.
    - in_loop=0, go=0 → IDLE.
- DBOUNCE: stay while go=1, → IDLE when go=0.
- done outside SHIP: ignored.
- ch_mask changes mid-frame: no effect. Only mask_q is used until the next frame start.
- Reset mid-operation: immediate return to IDLE, outputs 0, frame_cnt cleared.
- Minimum frame time: sum(shipper times) + (popcount−1) GAP cycles + LATCH_CYCLES.

Optional Feature:
- SHIP_TIMEOUT_EN defined:
  - A watchdog counts consecutive SHIP cycles, cleared on entry to SHIP.
  - Reaching TIMEOUT_CYCLES without done → ERR: ship_grb=0, timeout_err=1 (sticky).
  - ERR → IDLE only when go=0; timeout_err is cleared on that exit.
- Undefined: no watchdog logic, no ERR state, timeout_err tied 0.

Decomposition:
- Package ship_pkg holds:
  - the state enum (IDLE, SHIP, GAP, LATCH, DBOUNCE, ERR);
  - the ch_sel width function;
  - the default LATCH_CYCLES constant.
- One sub-module, ship_next_ch: combinational priority encoder returning the next set bit of mask_q above a given index, plus a valid flag. Also used for the lowest-set-bit case with index = −1.

Test Plan:
- NUM_CH=4, ch_mask=4'b1011, in_loop=0, go held, done 3 cycles after each ship_grb rise → ship_grb sequence 0001, GAP, 0010, GAP, 1000; then latching for LATCH_CYCLES; frame_done pulse; frame_cnt=1; DBOUNCE until go=0, then IDLE.
- in_loop=1, go held for 3 frames, mask 4'b0001 → three frame_done pulses; frame_cnt=3; no DBOUNCE visits; go drop during frame 3 → IDLE after that LATCH.
- ch_mask=0 with go=1 → busy stays 0, ship_grb=0 indefinitely. Then mask=4'b0100 → ship_grb=0100 on the next cycle.
- reset asserted mid-SHIP (ch_sel=1) → ship_grb, busy, latching and frame_cnt go to 0 asynchronously; after release, IDLE. done pulses while in IDLE or LATCH → no state change.
- ch_mask changed from 4'b1111 to 4'b0001 during SHIP of ch0 → all 4 strings are still shipped this frame.
- SHIP_TIMEOUT_EN, TIMEOUT_CYCLES=100, done never arrives → timeout_err=1 at SHIP cycle 100, ship_grb=0; go=0 → IDLE and timeout_err=0.
